modulator_sequencer: RTL and testbench

- Schedules the camera backscatter modulator by driving its trigger_signal input.
- Runs a programmable number of modulation bursts, each a high window, separated by low guard gaps.
- Timing is counted in the same 50-clock tick the modulator uses.
- Sits between the frame-control logic (config + start/abort) and the modulator; owns the only driver of trigger_signal.

---
 rtl/modulator_sequencer_pkg.sv | 23 ++
 rtl/modulator_sequencer_if.sv | 34 +++
 rtl/modulator_sequencer_tick_prescaler.sv | 35 +++
 rtl/modulator_sequencer.sv | 170 +++++++++++++++++
 tb/tb_modulator_sequencer.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/modulator_sequencer_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | modulator_pkg: shared types and constants for the modulator sequencer.  |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
package modulator_pkg;

   localparam int unsigned c_TICK_DIV       = 50;
   localparam int unsigned c_DEF_BURST_LEN  = 6100;
   localparam int unsigned c_DEF_GAP_LEN    = 100;
   localparam int unsigned c_DEF_NUM_BURSTS = 1;
   localparam int unsigned c_LEN_W          = 16;
   localparam int unsigned c_CNT_W          = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BURST = 2'd1,
      ST_GAP   = 2'd2,
      ST_DONE  = 2'd3
   } seq_state_t;

endpackage : modulator_pkg
`default_nettype wire

// File: rtl/modulator_sequencer_if.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | modulator_sequencer_if: frame-control / modulator bus of the sequencer. |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
interface modulator_sequencer_if;
   import modulator_pkg::*;

   logic               cfg_valid;
   logic               cfg_ready;
   logic [c_LEN_W-1:0] cfg_burst_len;
   logic [c_LEN_W-1:0] cfg_gap_len;
   logic [c_CNT_W-1:0] cfg_num_bursts;
   logic               cfg_error;
   logic               start;
   logic               abort;
   logic               trigger_signal;
   logic               busy;
   logic               done;
   logic               aborted;
   logic [c_CNT_W-1:0] burst_index;

   modport master (
      output cfg_valid, cfg_burst_len, cfg_gap_len, cfg_num_bursts, start, abort,
      input  cfg_ready, cfg_error, trigger_signal, busy, done, aborted, burst_index
   );

   modport slave (
      input  cfg_valid, cfg_burst_len, cfg_gap_len, cfg_num_bursts, start, abort,
      output cfg_ready, cfg_error, trigger_signal, busy, done, aborted, burst_index
   );

endinterface : modulator_sequencer_if
`default_nettype wire

// File: rtl/modulator_sequencer_tick_prescaler.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | tick_prescaler: emits one tick every TICK_DIV clocks, restartable.      |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
module tick_prescaler
   import modulator_pkg::*;
#(
   parameter int unsigned TICK_DIV = c_TICK_DIV
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   output logic tick
);

   localparam int unsigned     c_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [c_W-1:0]  c_LAST = c_W'(TICK_DIV - 1);

   logic [c_W-1:0] r_cnt;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_cnt <= '0;
      end else if (clear || (r_cnt == c_LAST)) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign tick = (r_cnt == c_LAST);

endmodule : tick_prescaler
`default_nettype wire

// File: rtl/modulator_sequencer.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | modulator_sequencer: schedules modulator bursts and guard gaps.         |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
module modulator_sequencer
   import modulator_pkg::*;
#(
   parameter int unsigned TICK_DIV       = c_TICK_DIV,
   parameter int unsigned DEF_BURST_LEN  = c_DEF_BURST_LEN,
   parameter int unsigned DEF_GAP_LEN    = c_DEF_GAP_LEN,
   parameter int unsigned DEF_NUM_BURSTS = c_DEF_NUM_BURSTS
) (
   input  logic                  clock,
   input  logic                  reset,
   modulator_sequencer_if.slave  bus
);

   localparam logic [c_LEN_W-1:0] c_RST_BURST = c_LEN_W'(DEF_BURST_LEN);
   localparam logic [c_LEN_W-1:0] c_RST_GAP   = c_LEN_W'(DEF_GAP_LEN);
   localparam logic [c_CNT_W-1:0] c_RST_NUM   = c_CNT_W'(DEF_NUM_BURSTS);

   seq_state_t          r_state;
   logic [c_LEN_W-1:0]  r_burst_len;
   logic [c_LEN_W-1:0]  r_gap_len;
   logic [c_CNT_W-1:0]  r_num_bursts;
   logic [c_LEN_W-1:0]  r_tick_cnt;
   logic [c_CNT_W-1:0]  r_burst_index;
   logic                r_trigger;
   logic                r_busy;
   logic                r_done;
   logic                r_aborted;
   logic                r_cfg_error;
   logic                r_cfg_ready;

   logic                w_tick;
   logic                w_clear;
   logic                w_cfg_accept;
   logic                w_cfg_ok;
   logic                w_start;
   logic                w_abort;
   logic                w_burst_end;
   logic                w_gap_end;
   logic                w_last_burst;
   logic [c_CNT_W-1:0]  w_idx_next;

   // cfg_ready is high exactly while in IDLE, so it doubles as the IDLE gate.
   assign w_cfg_accept = bus.cfg_valid && r_cfg_ready;
   assign w_cfg_ok     = w_cfg_accept && (bus.cfg_burst_len != '0);
   assign w_start      = (r_state == ST_IDLE) && bus.start && !bus.abort;
   assign w_abort      = (r_state != ST_IDLE) && bus.abort;

   assign w_burst_end  = (r_state == ST_BURST) && w_tick &&
                         (r_tick_cnt == (r_burst_len - 1'b1));
   // A zero-length gap still holds the trigger low for one clock.
   assign w_gap_end    = (r_state == ST_GAP) &&
                         ((r_gap_len == '0) ||
                          (w_tick && (r_tick_cnt == (r_gap_len - 1'b1))));
   assign w_idx_next   = r_burst_index + 1'b1;
   assign w_last_burst = (r_num_bursts != '0) && (w_idx_next == r_num_bursts);

   // Prescaler and tick counter both restart whenever a new state is entered.
   assign w_clear = (r_state == ST_IDLE) || (r_state == ST_DONE) ||
                    w_burst_end || w_gap_end || w_abort;

   tick_prescaler #(
      .TICK_DIV (TICK_DIV)
   ) u_tick_prescaler (
      .clock (clock),
      .reset (reset),
      .clear (w_clear),
      .tick  (w_tick)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state       <= ST_IDLE;
         r_burst_len   <= c_RST_BURST;
         r_gap_len     <= c_RST_GAP;
         r_num_bursts  <= c_RST_NUM;
         r_tick_cnt    <= '0;
         r_burst_index <= '0;
         r_trigger     <= 1'b0;
         r_busy        <= 1'b0;
         r_done        <= 1'b0;
         r_aborted     <= 1'b0;
         r_cfg_error   <= 1'b0;
         r_cfg_ready   <= 1'b1;
      end else begin
         r_done      <= 1'b0;
         r_aborted   <= 1'b0;
         r_cfg_error <= 1'b0;

         if (w_cfg_accept) begin
            if (w_cfg_ok) begin
               r_burst_len  <= bus.cfg_burst_len;
               r_gap_len    <= bus.cfg_gap_len;
               r_num_bursts <= bus.cfg_num_bursts;
            end else begin
               r_cfg_error  <= 1'b1;
            end
         end

         if (w_clear) begin
            r_tick_cnt <= '0;
         end else if (w_tick) begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
         end

         if (w_abort) begin
            r_state     <= ST_IDLE;
            r_trigger   <= 1'b0;
            r_busy      <= 1'b0;
            r_aborted   <= 1'b1;
            r_cfg_ready <= 1'b1;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  if (w_start) begin
                     r_state       <= ST_BURST;
                     r_trigger     <= 1'b1;
                     r_busy        <= 1'b1;
                     r_cfg_ready   <= 1'b0;
                     r_burst_index <= '0;
                  end
               end
               ST_BURST: begin
                  if (w_burst_end) begin
                     r_burst_index <= w_idx_next;
                     r_trigger     <= 1'b0;
                     if (w_last_burst) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                     end else begin
                        r_state <= ST_GAP;
                     end
                  end
               end
               ST_GAP: begin
                  if (w_gap_end) begin
                     r_state   <= ST_BURST;
                     r_trigger <= 1'b1;
                  end
               end
               ST_DONE: begin
                  r_state     <= ST_IDLE;
                  r_busy      <= 1'b0;
                  r_cfg_ready <= 1'b1;
               end
               default: begin
                  r_state     <= ST_IDLE;
                  r_trigger   <= 1'b0;
                  r_busy      <= 1'b0;
                  r_cfg_ready <= 1'b1;
               end
            endcase
         end
      end
   end

   assign bus.trigger_signal = r_trigger;
   assign bus.busy           = r_busy;
   assign bus.done           = r_done;
   assign bus.aborted        = r_aborted;
   assign bus.cfg_error      = r_cfg_error;
   assign bus.cfg_ready      = r_cfg_ready;
   assign bus.burst_index    = r_burst_index;

endmodule : modulator_sequencer
`default_nettype wire

// File: tb/tb_modulator_sequencer.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | tb_modulator_sequencer: trigger-pattern scoreboard bench, TICK_DIV = 4. |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
module tb_modulator_sequencer;

   localparam int c_DIV = 4;

   typedef struct {
      bit level;
      int len;
   } seg_t;

   typedef struct {
      int burst;
      int gap;
      int num;
      int exp_idx;
   } run_vec_t;

   logic clock = 1'b0;
   logic reset = 1'b0;

   modulator_sequencer_if bus ();

   modulator_sequencer #(
      .TICK_DIV (c_DIV)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   int   checks   = 0;
   int   failures = 0;
   seg_t exp_q[$];
   int   m_burst  = 6100;
   int   m_gap    = 100;
   int   m_num    = 1;
   bit   mon_en   = 1'b0;
   int   done_cnt = 0;
   int   hi_cnt   = 0;
   int   lo_cnt   = 0;
   bit   prev_trg = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic seg_cmp(input bit level, input int len);
      seg_t e;
      if (exp_q.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL unexpected_segment level=%0d len=%0d at %0t", level, len, $time);
      end else begin
         e = exp_q.pop_front();
         chk(level ? "seg_high_level" : "seg_low_level", int'(level), int'(e.level));
         chk(level ? "seg_high_len" : "seg_low_len", len, e.len);
      end
   endtask

   // Trigger-segment monitor; low segments count only while the run is busy.
   always @(negedge clock) begin
      if (!reset || !mon_en) begin
         hi_cnt   = 0;
         lo_cnt   = 0;
         prev_trg = 1'b0;
      end else begin
         if (bus.trigger_signal !== prev_trg) begin
            if (prev_trg) seg_cmp(1'b1, hi_cnt);
            else if (lo_cnt > 0) seg_cmp(1'b0, lo_cnt);
            hi_cnt = 0;
            lo_cnt = 0;
         end
         if (bus.trigger_signal) hi_cnt++;
         else if (bus.busy) lo_cnt++;
         else lo_cnt = 0;
         prev_trg = bus.trigger_signal;
         if (bus.done) done_cnt++;
      end
   end

   task automatic push_run(input int b, input int g, input int n);
      for (int i = 0; i < n; i++) begin
         exp_q.push_back('{level: 1'b1, len: b * c_DIV});
         if (i != n - 1) exp_q.push_back('{level: 1'b0, len: (g == 0) ? 1 : g * c_DIV});
      end
   endtask

   task automatic do_cfg(input int b, input int g, input int n, input bit exp_ready);
      @(negedge clock);
      chk("cfg_ready", bus.cfg_ready, exp_ready);
      bus.cfg_valid      = 1'b1;
      bus.cfg_burst_len  = 16'(b);
      bus.cfg_gap_len    = 16'(g);
      bus.cfg_num_bursts = 8'(n);
      @(negedge clock);
      bus.cfg_valid = 1'b0;
      chk("cfg_error", bus.cfg_error, (exp_ready && b == 0) ? 1 : 0);
      if (exp_ready && b != 0) begin
         m_burst = b;
         m_gap   = g;
         m_num   = n;
      end
   endtask

   task automatic start_run();
      @(negedge clock);
      bus.start = 1'b1;
      @(negedge clock);
      bus.start = 1'b0;
      chk("start_busy", bus.busy, 1);
      chk("start_trigger", bus.trigger_signal, 1);
      chk("start_index", bus.burst_index, 0);
   endtask

   task automatic wait_done(input int exp_idx, input int bound);
      int  d0;
      bit  seen;
      d0   = done_cnt;
      seen = 1'b0;
      for (int i = 0; i < bound; i++) begin
         @(negedge clock);
         if (bus.done) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) begin
         checks++;
         failures++;
         $display("FAIL done_timeout actual=0 required=1 after %0d cycles", bound);
      end else begin
         chk("done_busy", bus.busy, 1);
         chk("done_trigger", bus.trigger_signal, 0);
         chk("done_index", bus.burst_index, exp_idx);
         @(negedge clock);
         chk("post_done_busy", bus.busy, 0);
         chk("post_done_pulse", bus.done, 0);
         chk("done_count", done_cnt - d0, 1);
         chk("queue_empty", exp_q.size(), 0);
      end
   endtask

   task automatic chk_reset_state();
      chk("rst_trigger", bus.trigger_signal, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_aborted", bus.aborted, 0);
      chk("rst_cfg_error", bus.cfg_error, 0);
      chk("rst_index", bus.burst_index, 0);
      chk("rst_cfg_ready", bus.cfg_ready, 1);
   endtask

   initial begin
      run_vec_t vecs[4];
      bit       seen;
      vecs[0] = '{burst: 2, gap: 0, num: 2, exp_idx: 2};
      vecs[1] = '{burst: 1, gap: 0, num: 3, exp_idx: 3};
      vecs[2] = '{burst: 1, gap: 3, num: 1, exp_idx: 1};
      vecs[3] = '{burst: 3, gap: 2, num: 3, exp_idx: 3};

      bus.cfg_valid      = 1'b0;
      bus.cfg_burst_len  = '0;
      bus.cfg_gap_len    = '0;
      bus.cfg_num_bursts = '0;
      bus.start          = 1'b0;
      bus.abort          = 1'b0;

      repeat (3) @(negedge clock);
      chk_reset_state();
      reset  = 1'b1;
      mon_en = 1'b1;
      @(negedge clock);
      chk_reset_state();

      // Default configuration run.
      push_run(m_burst, m_gap, m_num);
      start_run();
      wait_done(1, 30000);

      foreach (vecs[i]) begin
         do_cfg(vecs[i].burst, vecs[i].gap, vecs[i].num, 1'b1);
         push_run(m_burst, m_gap, m_num);
         start_run();
         wait_done(vecs[i].exp_idx, 2000);
      end

      // Rejected config, then a config attempt while busy.
      do_cfg(0, 5, 5, 1'b1);
      push_run(m_burst, m_gap, m_num);
      start_run();
      do_cfg(7, 7, 7, 1'b0);
      wait_done(3, 2000);

      // Continuous mode aborted in the gap after the fifth burst.
      do_cfg(2, 1, 0, 1'b1);
      push_run(2, 1, 5);
      start_run();
      seen = 1'b0;
      for (int i = 0; i < 500; i++) begin
         @(negedge clock);
         if (bus.burst_index == 8'd5) begin
            seen = 1'b1;
            break;
         end
      end
      chk("idx5_reached", int'(seen), 1);
      @(negedge clock);
      chk("gap_trigger_low", bus.trigger_signal, 0);
      bus.abort = 1'b1;
      @(negedge clock);
      bus.abort = 1'b0;
      chk("abort_trigger", bus.trigger_signal, 0);
      chk("abort_pulse", bus.aborted, 1);
      chk("abort_done", bus.done, 0);
      chk("abort_busy", bus.busy, 0);
      chk("abort_index", bus.burst_index, 5);
      @(negedge clock);
      chk("abort_pulse_end", bus.aborted, 0);
      chk("abort_queue_empty", exp_q.size(), 0);

      // Start and abort together in IDLE.
      @(negedge clock);
      bus.start = 1'b1;
      bus.abort = 1'b1;
      @(negedge clock);
      bus.start = 1'b0;
      bus.abort = 1'b0;
      chk("sa_busy", bus.busy, 0);
      chk("sa_trigger", bus.trigger_signal, 0);
      chk("sa_aborted", bus.aborted, 0);

      // Asynchronous reset in the middle of a burst.
      do_cfg(40, 1, 2, 1'b1);
      push_run(m_burst, m_gap, m_num);
      start_run();
      repeat (20) @(negedge clock);
      chk("pre_reset_trigger", bus.trigger_signal, 1);
      mon_en = 1'b0;
      exp_q.delete();
      #1 reset = 1'b0;
      #1;
      chk("async_trigger", bus.trigger_signal, 0);
      chk("async_busy", bus.busy, 0);
      chk("async_cfg_ready", bus.cfg_ready, 1);
      @(negedge clock);
      reset   = 1'b1;
      mon_en  = 1'b1;
      m_burst = 6100;
      m_gap   = 100;
      m_num   = 1;
      @(negedge clock);
      chk_reset_state();
      push_run(m_burst, m_gap, m_num);
      start_run();
      wait_done(1, 30000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_modulator_sequencer
`default_nettype wire
